// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with a byte FIFO and an 8N1 serial shifter.
// Define MMIO_UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module mmio_uart_tx #(
  parameter logic [31:0] BASE        = 32'h0000_0400,
  parameter int          DEPTH       = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [31:0] a,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        tx
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef MMIO_UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t        state_q;
  logic          tx_q;
  logic [15:0]   baud_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic [15:0]   cur_div_q;
  logic [15:0]   div_q;
  logic          ovf_q, ovf_d;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
`ifdef MMIO_UART_TX_PARITY_EN
  logic          par_q;
  localparam logic PAR_BIT = 1'b1;
`else
  localparam logic PAR_BIT = 1'b0;
`endif

  logic [29:0] word;
  logic        sel_data, sel_stat, sel_div;
  logic        full, empty, busy, push, pop, baud_last;
  logic [7:0]  head;
  logic        unused_ok;

  assign word      = a[31:2];
  assign sel_data  = (word == BASE[31:2]);
  assign sel_stat  = (word == BASE[31:2] + 30'd1);
  assign sel_div   = (word == BASE[31:2] + 30'd2);
  assign full      = (count_q == FULL_CNT);
  assign empty     = (count_q == '0);
  assign busy      = (state_q != S_IDLE);
  assign push      = we && sel_data && !full;
  assign pop       = (state_q == S_IDLE) && !empty;
  assign head      = mem_q[rd_ptr_q];
  assign baud_last = (baud_q == cur_div_q - 16'd1);
  assign tx        = tx_q;
  assign unused_ok = ^{wd[31:16], a[1:0]};

  always_comb begin
    rd = 32'h0;
    if (sel_stat)     rd = {27'h0, PAR_BIT, ovf_q, empty, full, busy};
    else if (sel_div) rd = {16'h0, div_q};
  end

  // A dropped write sets ovf even when a clear lands on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (we && sel_stat && wd[3]) ovf_d = 1'b0;
    if (we && sel_data && full)  ovf_d = 1'b1;
    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wd[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      div_q    <= DEFAULT_DIV;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      if (we && sel_div) div_q <= (wd[15:0] == 16'h0) ? 16'd1 : wd[15:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tx_q      <= 1'b1;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      cur_div_q <= DEFAULT_DIV;
`ifdef MMIO_UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            state_q   <= S_START;
            tx_q      <= 1'b0;
            baud_q    <= '0;
            shift_q   <= head;
            cur_div_q <= div_q;
`ifdef MMIO_UART_TX_PARITY_EN
            par_q     <= ^head;
`endif
          end
        end
        S_START: begin
          if (baud_last) begin
            baud_q  <= '0;
            bit_q   <= '0;
            state_q <= S_DATA;
            tx_q    <= shift_q[0];
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        S_DATA: begin
          if (baud_last) begin
            baud_q <= '0;
            if (bit_q == 3'd7) begin
`ifdef MMIO_UART_TX_PARITY_EN
              state_q <= S_PARITY;
              tx_q    <= par_q;
`else
              state_q <= S_STOP;
              tx_q    <= 1'b1;
`endif
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
`ifdef MMIO_UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= S_STOP;
            tx_q    <= 1'b1;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
`endif
        S_STOP: begin
          if (baud_last) begin
            baud_q  <= '0;
            state_q <= S_IDLE;
          end else begin
            baud_q <= baud_q + 16'd1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - scoreboard bench: stimulus queues expected frames, a tx monitor decodes and checks them.
module tb_mmio_uart_tx;

  localparam logic [31:0] BASE = 32'h0000_0400;
  localparam logic [31:0] A_DATA = BASE;
  localparam logic [31:0] A_STAT = BASE + 32'd4;
  localparam logic [31:0] A_DIV  = BASE + 32'd8;
`ifdef MMIO_UART_TX_PARITY_EN
  localparam int PAR_EN = 1;
  localparam logic [31:0] PBIT = 32'h10;
`else
  localparam int PAR_EN = 0;
  localparam logic [31:0] PBIT = 32'h0;
`endif

  logic        clk, reset, we, tx;
  logic [31:0] a, wd, rd;

  typedef struct {
    logic [7:0] data;
    int         div;
  } exp_t;

  exp_t exp_q[$];
  int   starts[$];
  int   checks, failures, frames, cyc;
  logic mon_en, prev_tx;

  mmio_uart_tx #(.BASE(BASE), .DEPTH(4), .DEFAULT_DIV(16'd4)) dut (
    .clk(clk), .reset(reset), .we(we), .a(a), .wd(wd), .rd(rd), .tx(tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    we = 1'b1; a = addr; wd = data;
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic rdchk(input string name, input logic [31:0] addr, input logic [31:0] exp);
    a = addr;
    #1;
    check(name, rd, exp);
  endtask

  task automatic expect_frame(input logic [7:0] data, input int div);
    exp_t e;
    e.data = data; e.div = div;
    exp_q.push_back(e);
  endtask

  // Monitor: on each start-bit edge, compare every tx sample of the frame against the expected byte.
  initial begin
    exp_t e;
    logic [10:0] bits;
    int nbits, bad;
    prev_tx = 1'b1;
    forever begin
      @(negedge clk);
      if (mon_en && prev_tx && !tx) begin
        frames++;
        starts.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_frame got=frame expected=idle");
        end else begin
          e = exp_q.pop_front();
          nbits = (PAR_EN != 0) ? 11 : 10;
          bits = {1'b1, (PAR_EN != 0) ? ^e.data : 1'b1, e.data, 1'b0};
          bad = 0;
          for (int b = 0; b < nbits; b++) begin
            for (int c = 0; c < e.div; c++) begin
              if (!(b == 0 && c == 0)) @(negedge clk);
              if (tx !== bits[b]) bad++;
            end
          end
          check($sformatf("frame_%h_bad_samples", e.data), bad, 0);
        end
      end
      prev_tx = tx;
    end
  end

  initial begin
    int nb, nlow;
    checks = 0; failures = 0; frames = 0; cyc = 0;
    mon_en = 1'b0;
    reset = 1'b1; we = 1'b0; a = 32'h0; wd = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    rdchk("reset_status", A_STAT, 32'h4 | PBIT);
    check("reset_tx", tx, 1);
    rdchk("reset_div", A_DIV, 32'h4);
    rdchk("unmapped_c", BASE + 32'd12, 32'h0);
    rdchk("data_reads_0", A_DATA, 32'h0);

    // Single 8'hA5 frame at 2 clocks per bit with latency and busy checks.
    mon_en = 1'b1;
    wr(A_DIV, 32'd2);
    expect_frame(8'hA5, 2);
    wr(A_DATA, 32'hA5);
    check("a5_tx_before_start", tx, 1);
    rdchk("a5_status_pushed", A_STAT, 32'h0 | PBIT);
    @(negedge clk);
    check("a5_tx_start_edge", tx, 0);
    rdchk("a5_status_busy", A_STAT, 32'h5 | PBIT);
    nb = 0;
    for (int i = 1; i < 10 * 2 + 2 * PAR_EN; i++) begin
      @(negedge clk); #1;
      if (rd[0] !== 1'b1) nb++;
    end
    check("a5_busy_throughout", nb, 0);
    @(negedge clk);
    rdchk("a5_idle_after", A_STAT, 32'h4 | PBIT);

    // Burst of six bytes at div 1: one pops immediately, four fill the FIFO, the sixth overflows.
    wr(A_DIV, 32'd1);
    starts.delete();
    for (int i = 1; i <= 5; i++) expect_frame(8'(8'h11 * i), 1);
    for (int i = 1; i <= 6; i++) wr(A_DATA, 32'(8'h11 * i));
    rdchk("burst_full_ovf", A_STAT, 32'hB | PBIT);
    wr(A_STAT, 32'h8);
    rdchk("ovf_clear", A_STAT, 32'h3 | PBIT);
    wr(A_DATA, 32'h77);
    rdchk("ovf_set_again", A_STAT, 32'hB | PBIT);
    wr(A_STAT, 32'h7);
    rdchk("ovf_no_clear_bit3_0", A_STAT, 32'hB | PBIT);
    wr(A_STAT, 32'h8);
    rdchk("ovf_clear_again", A_STAT, 32'h3 | PBIT);
    repeat (70) @(negedge clk);
    check("burst_queue_drained", exp_q.size(), 0);
    check("burst_frames_seen", frames, 6);
    if (starts.size() >= 3) check("back_to_back_gap", starts[2] - starts[1], 11 + PAR_EN);
    else check("back_to_back_starts", starts.size(), 3);
    rdchk("burst_idle", A_STAT, 32'h4 | PBIT);

    // DIV of zero stores one; a DIV write mid-frame only affects the next frame.
    wr(A_DIV, 32'd0);
    rdchk("div_zero_is_one", A_DIV, 32'h1);
    wr(A_DIV, 32'd2);
    expect_frame(8'hC3, 2);
    expect_frame(8'h3C, 8);
    wr(A_DATA, 32'hC3);
    wr(A_DATA, 32'h3C);
    repeat (5) @(negedge clk);
    wr(A_DIV, 32'd8);
    rdchk("div_eight", A_DIV, 32'h8);
    repeat (120) @(negedge clk);
    check("div_queue_drained", exp_q.size(), 0);
    check("div_frames_seen", frames, 8);

    // Reset in the middle of the data bits of a zero byte.
    mon_en = 1'b0;
    wr(A_DIV, 32'd4);
    wr(A_DATA, 32'h00);
    wr(A_DATA, 32'h00);
    repeat (8) @(negedge clk);
    check("mid_data_tx_low", tx, 0);
    a = A_STAT;
    #2 reset = 1'b1;
    #1;
    check("async_reset_tx", tx, 1);
    check("async_reset_status", rd, 32'h4 | PBIT);
    @(negedge clk);
    reset = 1'b0;
    nlow = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) nlow++;
    end
    check("flushed_no_frame", nlow, 0);
    rdchk("after_reset_div", A_DIV, 32'h4);

`ifdef MMIO_UART_TX_PARITY_EN
    mon_en = 1'b1;
    prev_tx = 1'b1;
    wr(A_DIV, 32'd1);
    expect_frame(8'h07, 1);
    wr(A_DATA, 32'h07);
    nb = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 9 && tx !== 1'b1) nb++;
    end
    check("parity_07_bit", nb, 0);
    repeat (4) @(negedge clk);
    check("parity_queue_drained", exp_q.size(), 0);
`endif

    check("final_queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
